// File: rtl/shift_sequencer.sv
// shift_sequencer: iterative shifter that performs one 1-bit step per cycle through an IDLE/SHIFT/DONE FSM.
// Define SHIFT_SEQ_ROTATE_EN to turn mode 00 from an illegal mode into rotate-left.
module shift_sequencer #(
  parameter int DATA_W = 16,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] op_x,
  input  logic [DATA_W-1:0] op_y,
  input  logic [2:0]        op_en,
  input  logic [CNT_W-1:0]  shamt,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] op_out
);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
  logic [1:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] work_q, work_d, out_q, out_d, step;
  logic              err_q, err_d, legal;
`ifdef SHIFT_SEQ_ROTATE_EN
  assign legal = 1'b1;
`else
  assign legal = |op_en[1:0];
`endif
  // mode 00 only reaches the work register when rotate is enabled
  assign step = mode_q == 2'b01 ? {work_q[DATA_W-2:0], 1'b0} :
                mode_q == 2'b10 ? {1'b0, work_q[DATA_W-1:1]} :
                mode_q == 2'b11 ? {work_q[DATA_W-1], work_q[DATA_W-1:1]} :
                                  {work_q[DATA_W-2:0], work_q[DATA_W-1]};
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    cnt_d = cnt_q;
    work_d = work_q;
    out_d = out_q;
    err_d = 1'b0;
    if (state_q == IDLE) begin
      if (start && legal) begin
        work_d = op_en[2] ? op_y : op_x;
        mode_d = op_en[1:0];
        cnt_d = shamt;
        state_d = SHIFT;
      end else if (start) begin
        out_d = '0;
        err_d = 1'b1;
        state_d = DONE;
      end
    end else if (state_q == SHIFT) begin
      if (cnt_q != '0) begin
        work_d = step;
        cnt_d = cnt_q - 1'b1;
      end else begin
        out_d = work_q;
        state_d = DONE;
      end
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q <= '0;
      cnt_q <= '0;
      work_q <= '0;
      out_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      cnt_q <= cnt_d;
      work_q <= work_d;
      out_q <= out_d;
      err_q <= err_d;
    end
  end
  assign busy = state_q == SHIFT;
  assign done = state_q == DONE;
  assign err = err_q;
  assign op_out = out_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: randomized and directed checks of shift_sequencer against an arithmetic reference model.
module tb_shift_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [15:0] op_x = '0, op_y = '0;
  logic [2:0] op_en = '0;
  logic [3:0] shamt = '0;
  logic busy, done, err;
  logic [15:0] op_out;
  int checks = 0, failures = 0;

  shift_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op_x(op_x), .op_y(op_y), .op_en(op_en),
    .shamt(shamt), .busy(busy), .done(done), .err(err), .op_out(op_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic bit is_illegal(logic [2:0] en);
`ifdef SHIFT_SEQ_ROTATE_EN
    return 1'b0;
`else
    return en[1:0] == 2'b00;
`endif
  endfunction

  function automatic logic [15:0] model(logic [15:0] x, logic [15:0] y, logic [2:0] en, int sh);
    logic [15:0] v = en[2] ? y : x;
    logic [31:0] t = {v, v} << sh;
    if (is_illegal(en)) return 16'h0000;
    case (en[1:0])
      2'b01: return v << sh;
      2'b10: return v >> sh;
      2'b11: return 16'($signed(v) >>> sh);
      default: return t[31:16];
    endcase
  endfunction

  // Pulses start for one edge, then follows the operation until done or a cycle budget runs out.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic [2:0] en, input logic [3:0] sh,
                        output int edges, output int busy_n, output logic [15:0] out, output logic e,
                        output bit to, output bit ov, output logic d2, output logic e2);
    @(negedge clk);
    op_x = x; op_y = y; op_en = en; shamt = sh; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    op_x = 16'($urandom); op_y = 16'($urandom); shamt = 4'($urandom);
    edges = 1; busy_n = 0; ov = 1'b0;
    while (!done && edges < 40) begin
      busy_n += int'(busy);
      @(posedge clk);
      #1 edges++;
    end
    to = !done; ov = busy && done; out = op_out; e = err;
    @(posedge clk);
    #1 d2 = done; e2 = err;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; op_en = 3'b001; shamt = 4'd3;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (op_out !== 16'h0) begin failures++; $display("FAIL reset_out got=%h exp=0000", op_out); end
    start = 1'b0; rst = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_sll;
    int ed, bn; logic [15:0] o; logic e, d2, e2; bit to, ov;
    run_op(16'h0001, 16'h1234, 3'b001, 4'd15, ed, bn, o, e, to, ov, d2, e2);
    checks++; if (to) begin failures++; $display("FAIL sll_timeout got=no_done exp=done"); end
    checks++; if (bn !== 16) begin failures++; $display("FAIL sll_busy got=%0d exp=16", bn); end
    checks++; if (ed !== 17) begin failures++; $display("FAIL sll_latency got=%0d exp=17", ed); end
    checks++; if (o !== 16'h8000) begin failures++; $display("FAIL sll_out got=%h exp=8000", o); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL sll_err got=%b exp=0", e); end
    checks++; if (d2 !== 1'b0) begin failures++; $display("FAIL sll_done_width got=%b exp=0", d2); end
  endtask

  task automatic test_sra;
    int ed, bn; logic [15:0] o; logic e, d2, e2; bit to, ov;
    run_op(16'h0000, 16'h8000, 3'b111, 4'd15, ed, bn, o, e, to, ov, d2, e2);
    checks++; if (o !== 16'hFFFF) begin failures++; $display("FAIL sra_out got=%h exp=ffff", o); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL sra_err got=%b exp=0", e); end
    run_op(16'h0000, 16'h8000, 3'b110, 4'd15, ed, bn, o, e, to, ov, d2, e2);
    checks++; if (o !== 16'h0001) begin failures++; $display("FAIL srl_y_out got=%h exp=0001", o); end
  endtask

  task automatic test_zero_shift;
    int ed, bn; logic [15:0] o; logic e, d2, e2; bit to, ov;
    run_op(16'hA5A5, 16'h0F0F, 3'b010, 4'd0, ed, bn, o, e, to, ov, d2, e2);
    checks++; if (ed !== 2) begin failures++; $display("FAIL zero_latency got=%0d exp=2", ed); end
    checks++; if (o !== 16'hA5A5) begin failures++; $display("FAIL zero_out got=%h exp=a5a5", o); end
    checks++; if (bn !== 1) begin failures++; $display("FAIL zero_busy got=%0d exp=1", bn); end
    checks++; if (ov) begin failures++; $display("FAIL zero_overlap got=busy_and_done exp=exclusive"); end
  endtask

  task automatic test_illegal;
    int ed, bn; logic [15:0] o; logic e, d2, e2; bit to, ov;
`ifdef SHIFT_SEQ_ROTATE_EN
    run_op(16'h8001, 16'h0000, 3'b000, 4'd1, ed, bn, o, e, to, ov, d2, e2);
    checks++; if (o !== 16'h0003) begin failures++; $display("FAIL rol_out got=%h exp=0003", o); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL rol_err got=%b exp=0", e); end
`else
    run_op(16'h1111, 16'h2222, 3'b100, 4'd7, ed, bn, o, e, to, ov, d2, e2);
    checks++; if (ed !== 1) begin failures++; $display("FAIL illegal_latency got=%0d exp=1", ed); end
    checks++; if (o !== 16'h0000) begin failures++; $display("FAIL illegal_out got=%h exp=0000", o); end
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL illegal_err got=%b exp=1", e); end
    checks++; if (e2 !== 1'b0) begin failures++; $display("FAIL illegal_err_width got=%b exp=0", e2); end
    checks++; if (bn !== 0) begin failures++; $display("FAIL illegal_busy got=%0d exp=0", bn); end
`endif
  endtask

  task automatic test_busy_filter;
    int dones = 0; logic [15:0] got = '0;
    @(negedge clk);
    op_x = 16'h00F0; op_y = 16'h0000; op_en = 3'b001; shamt = 4'd6; start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 12; i++) begin
      #1;
      if (done) begin dones++; got = op_out; start = 1'b0; break; end
      op_x = 16'($urandom); op_y = 16'($urandom); op_en = 3'($urandom); shamt = 4'($urandom);
      @(posedge clk);
    end
    start = 1'b0;
    repeat (20) begin @(posedge clk); #1 if (done) dones++; end
    checks++; if (got !== 16'h3C00) begin failures++; $display("FAIL filter_out got=%h exp=3c00", got); end
    checks++; if (dones !== 1) begin failures++; $display("FAIL filter_dones got=%0d exp=1", dones); end
  endtask

  task automatic test_mid_reset;
    int ed, bn, dones = 0; logic [15:0] o; logic e, d2, e2; bit to, ov;
    run_op(16'h00FF, 16'h0000, 3'b001, 4'd4, ed, bn, o, e, to, ov, d2, e2);
    @(negedge clk);
    op_x = 16'h0003; op_en = 3'b001; shamt = 4'd10; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) begin @(posedge clk); #1 if (done) dones++; end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (op_out !== 16'h0) begin failures++; $display("FAIL abort_out got=%h exp=0000", op_out); end
    repeat (15) begin @(posedge clk); #1 if (done) dones++; end
    checks++; if (dones !== 0) begin failures++; $display("FAIL abort_done got=%0d exp=0", dones); end
    run_op(16'h0003, 16'h0000, 3'b001, 4'd10, ed, bn, o, e, to, ov, d2, e2);
    checks++; if (o !== 16'h0C00) begin failures++; $display("FAIL after_abort_out got=%h exp=0c00", o); end
  endtask

  task automatic test_random;
    int ed, bn; logic [15:0] o, x, y, exp_o; logic e, d2, e2; bit to, ov, ill;
    logic [2:0] en; logic [3:0] sh;
    for (int i = 0; i < 60; i++) begin
      x = 16'($urandom); y = 16'($urandom); en = 3'($urandom); sh = 4'($urandom);
      ill = is_illegal(en);
      exp_o = model(x, y, en, int'(sh));
      run_op(x, y, en, sh, ed, bn, o, e, to, ov, d2, e2);
      checks++; if (o !== exp_o) begin failures++; $display("FAIL rand_out[%0d] en=%b sh=%0d got=%h exp=%h", i, en, sh, o, exp_o); end
      checks++; if (e !== ill) begin failures++; $display("FAIL rand_err[%0d] got=%b exp=%b", i, e, ill); end
      checks++; if (ed !== (ill ? 1 : int'(sh) + 2)) begin failures++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", i, ed, ill ? 1 : int'(sh) + 2); end
      checks++; if (bn !== (ill ? 0 : int'(sh) + 1)) begin failures++; $display("FAIL rand_busy[%0d] got=%0d exp=%0d", i, bn, ill ? 0 : int'(sh) + 1); end
      checks++; if (ov || d2 !== 1'b0) begin failures++; $display("FAIL rand_done_shape[%0d] got=ov%b/d2%b exp=0/0", i, ov, d2); end
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_sll();
    test_sra();
    test_zero_shift();
    test_illegal();
    test_busy_filter();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
